// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and parameter helpers for the clock-gate sequencer.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        CG_OFF  = 2'b00,
        CG_WAKE = 2'b01,
        CG_ON   = 2'b10,
        CG_HOLD = 2'b11
    } cg_state_e;

    // Width of a down-counter that must hold values up to max(a, b).
    function automatic int unsigned cg_cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

    // Legal configuration: at least two domains, non-zero wake and idle times.
    function automatic bit cg_params_ok(input int unsigned num_domains,
                                        input int unsigned wake_cycles,
                                        input int unsigned idle_cycles);
        return (num_domains >= 2) && (wake_cycles >= 1) && (idle_cycles >= 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; the pointer advances past each issued grant.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] r_rr;
    logic [N-1:0]     w_gnt;
    logic             w_found;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [IDX_W-1:0] w_idx;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        w_gnt     = '0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = IDX_W'((32'(r_rr) + i) % N);
            if (!w_found && req_i[w_idx]) begin
                w_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
                w_gnt_idx    = w_idx;
            end
        end
    end

    assign gnt_o = en_i ? w_gnt : '0;

    // Pointer moves only when a grant is actually issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr <= '0;
        end else if (en_i && w_found) begin
            r_rr <= (w_gnt_idx == IDX_W'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gate sequencer: serialised wake-up, delayed gate-off.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned IDLE_CYCLES = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_DOMAINS-1:0] req_i,
    input  logic [NUM_DOMAINS-1:0] force_on_i,
    output logic [NUM_DOMAINS-1:0] en_o,
    output logic [NUM_DOMAINS-1:0] ack_o,
    output logic                   wake_busy_o
);

    localparam int unsigned CNT_W = cg_cnt_width(WAKE_CYCLES, IDLE_CYCLES);

    if (!cg_params_ok(NUM_DOMAINS, WAKE_CYCLES, IDLE_CYCLES)) begin : g_bad_params
        $error("clk_gate_ctrl: illegal NUM_DOMAINS/WAKE_CYCLES/IDLE_CYCLES");
    end

    logic [NUM_DOMAINS-1:0] w_dem;
    logic [NUM_DOMAINS-1:0] w_cand;
    logic [NUM_DOMAINS-1:0] w_in_wake;
    logic [NUM_DOMAINS-1:0] w_gnt;
    logic                   w_wake_busy;

    assign w_dem       = req_i | force_on_i;
    assign w_wake_busy = |w_in_wake;
    assign wake_busy_o = w_wake_busy;

    // Grants are only issued while nobody is waking, limiting rail inrush.
    rr_arbiter #(
        .N (NUM_DOMAINS)
    ) u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (w_cand),
        .en_i  (~w_wake_busy),
        .gnt_o (w_gnt)
    );

    for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_dom
        cg_state_e        r_state;
        logic [CNT_W-1:0] r_cnt;

        assign w_cand[k]    = w_dem[k] && (r_state == CG_OFF);
        assign w_in_wake[k] = (r_state == CG_WAKE);
        assign en_o[k]      = (r_state != CG_OFF);
        assign ack_o[k]     = (r_state == CG_ON) || (r_state == CG_HOLD);

        // Domain FSM and its shared wake/idle down-counter.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_state <= CG_OFF;
                r_cnt   <= '0;
            end else begin
                unique case (r_state)
                    CG_OFF: begin
                        if (w_gnt[k]) begin
                            r_state <= CG_WAKE;
                            r_cnt   <= CNT_W'(WAKE_CYCLES - 1);
                        end
                    end
                    // Wake always runs to completion, even if demand drops.
                    CG_WAKE: begin
                        if (r_cnt == '0) begin
                            r_state <= CG_ON;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    CG_ON: begin
                        if (!w_dem[k]) begin
                            r_state <= CG_HOLD;
                            r_cnt   <= CNT_W'(IDLE_CYCLES - 1);
                        end
                    end
                    // Renewed demand beats expiry, so the clock never glitches off.
                    CG_HOLD: begin
                        if (w_dem[k]) begin
                            r_state <= CG_ON;
                        end else if (r_cnt == '0) begin
                            r_state <= CG_OFF;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= CG_OFF;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl (4 domains, WAKE=2, IDLE=16).
module tb_clk_gate_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] frc;
    logic [3:0] en;
    logic [3:0] ack;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    clk_gate_ctrl #(
        .NUM_DOMAINS (4),
        .WAKE_CYCLES (2),
        .IDLE_CYCLES (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .force_on_i  (frc),
        .en_o        (en),
        .ack_o       (ack),
        .wake_busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One active edge, then sample/drive 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = 4'b0000;
        frc = 4'b0000;
        ticks(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        frc = 4'b0000;

        // Single domain wake and release.
        apply_reset();
        check("rst_en", 32'(en), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        ticks(2);
        req = 4'b0001;
        tick();
        check("t1_en_E", 32'(en), 32'h1);
        check("t1_ack_E", 32'(ack), 32'h0);
        check("t1_busy_E", 32'(busy), 32'h1);
        tick();
        check("t1_ack_E1", 32'(ack), 32'h0);
        tick();
        check("t1_ack_E2", 32'(ack), 32'h1);
        check("t1_busy_E2", 32'(busy), 32'h0);
        ticks(12);
        req = 4'b0000;
        tick();
        check("t1_hold_en", 32'(en), 32'h1);
        check("t1_hold_ack", 32'(ack), 32'h1);
        ticks(15);
        check("t1_en_R15", 32'(en), 32'h1);
        tick();
        check("t1_en_R16", 32'(en), 32'h0);
        check("t1_ack_R16", 32'(ack), 32'h0);

        // All four request together: serialised wakes 0,1,2,3.
        apply_reset();
        req = 4'b1111;
        tick();
        check("t2_en_E0", 32'(en), 32'h1);
        check("t2_busy_E0", 32'(busy), 32'h1);
        tick();
        check("t2_busy_E1", 32'(busy), 32'h1);
        tick();
        check("t2_en_E2", 32'(en), 32'h1);
        check("t2_ack_E2", 32'(ack), 32'h1);
        tick();
        check("t2_en_E3", 32'(en), 32'h3);
        check("t2_busy_E3", 32'(busy), 32'h1);
        ticks(3);
        check("t2_en_E6", 32'(en), 32'h7);
        ticks(3);
        check("t2_en_E9", 32'(en), 32'hf);
        check("t2_busy_E9", 32'(busy), 32'h1);
        tick();
        check("t2_ack_E10", 32'(ack), 32'h7);
        check("t2_busy_E10", 32'(busy), 32'h1);
        tick();
        check("t2_ack_E11", 32'(ack), 32'hf);
        check("t2_busy_E11", 32'(busy), 32'h0);

        // Pointer at 2 with requests on 0 and 3: 3 first, then 0.
        apply_reset();
        req = 4'b0010;
        tick();
        req = 4'b1001;
        ticks(2);
        check("t3_ack_d1", 32'(ack), 32'h2);
        tick();
        check("t3_en_d3_first", 32'(en), 32'ha);
        ticks(2);
        check("t3_en_d0_wait", 32'(en), 32'ha);
        check("t3_ack_d3", 32'(ack), 32'ha);
        tick();
        check("t3_en_d0_gnt", 32'(en), 32'hb);

        // Re-request on the last HOLD cycle keeps the clock running.
        apply_reset();
        req = 4'b0010;
        ticks(3);
        req = 4'b0000;
        tick();
        ticks(15);
        check("t4_en_cnt0", 32'(en), 32'h2);
        req = 4'b0010;
        tick();
        check("t4_en_rereq", 32'(en), 32'h2);
        check("t4_ack_rereq", 32'(ack), 32'h2);
        req = 4'b0000;
        tick();
        ticks(15);
        check("t4_en_R15", 32'(en), 32'h2);
        tick();
        check("t4_en_R16", 32'(en), 32'h0);

        // Force-on behaves as a request and persists.
        apply_reset();
        frc = 4'b0100;
        tick();
        check("t5_en_E", 32'(en), 32'h4);
        ticks(2);
        check("t5_ack_E2", 32'(ack), 32'h4);
        ticks(50);
        check("t5_ack_long", 32'(ack), 32'h4);
        check("t5_en_long", 32'(en), 32'h4);
        frc = 4'b0000;
        tick();
        check("t5_ack_hold", 32'(ack), 32'h4);
        ticks(15);
        check("t5_en_R15", 32'(en), 32'h4);
        tick();
        check("t5_en_R16", 32'(en), 32'h0);

        // Reset with d0 in WAKE and d1 in HOLD; pointer returns to 0.
        apply_reset();
        req = 4'b0010;
        ticks(3);
        req = 4'b0001;
        tick();
        check("t6_pre_en", 32'(en), 32'h3);
        check("t6_pre_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        req = 4'b0011;
        tick();
        check("t6_rst_en", 32'(en), 32'h0);
        check("t6_rst_ack", 32'(ack), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();
        check("t6_first_gnt", 32'(en), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
